tx_fir_tap_ctrl: RTL and testbench
==================================

TX_FIR_TAP_CTRL -- requirements
Module: tx_fir_tap_ctrl

Interface
REQ-001 SHALL have parameter NTAP, default 6: width of the tap codes.
REQ-002 SHALL have parameter SUM_CODE, default 48: constant value of tap0_code + tap1_code (fixed swing).
REQ-003 SHALL have parameter POST_INIT, default 8: tap1_code value after reset or re-train.
REQ-004 SHALL have parameter POST_MAX, default 24: upper limit of tap1_code.
REQ-005 SHALL have parameter HOLDOFF, default 16: settle cycles after each tap update.
REQ-006 SHALL have parameter TRAIN_LEN, default 1023: training timeout in cycles.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its posedge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port en, input, 1 bit: link enable; its rising edge starts training.
REQ-010 SHALL have port data_in, input, 1 bit: mission data bit.
REQ-011 SHALL have port fb_valid, input, 1 bit: back-channel command valid.
REQ-012 SHALL have port fb_cmd, input, 2 bits: 00 hold, 01 post-increment, 10 post-decrement, 11 done.
REQ-013 SHALL have port fb_ready, output, 1 bit: command may be accepted this cycle.
REQ-014 SHALL have port tx_bit, output, 1 bit: bit driven to the 2-tap FIR in input.
REQ-015 SHALL have port tap0_code, output, NTAP bits: main-cursor weight code.
REQ-016 SHALL have port tap1_code, output, NTAP bits: post-cursor weight code.
REQ-017 SHALL have port tap_upd, output, 1 bit: one-cycle pulse when the tap codes change.
REQ-018 SHALL have port state, output, 2 bits: 0 IDLE, 1 TRAIN, 2 SETTLE, 3 DATA.
REQ-019 SHALL have port timeout, output, 1 bit: sticky flag, training ended by timeout.

Function
REQ-020 SHALL implement FSM IDLE->TRAIN on en rising edge (en=1 now, 0 last cycle); TRAIN<->SETTLE per REQ-024; TRAIN->DATA on accepted done or timeout.
REQ-021 SHALL force state to IDLE on the next cycle from any state when en=0; tap codes hold their values.
REQ-022 SHALL, on entering TRAIN from IDLE:
- load tap1=POST_INIT and tap0=SUM_CODE-POST_INIT;
- seed PRBS7 (x^7+x^6+1) to 7'h7F;
- clear the cycle counter and timeout.
REQ-023 SHALL register tx_bit:
- IDLE: 0.
- TRAIN/SETTLE: PRBS7 MSB, advancing one step every cycle.
- DATA: data_in delayed one cycle.
REQ-024 SHALL drive fb_ready=1 only in TRAIN; a command is accepted when fb_valid & fb_ready.
- Accepted inc/dec with a legal result: tap codes update next cycle, tap_upd pulses that cycle, state goes to SETTLE for HOLDOFF cycles, then returns to TRAIN.
- Accepted hold: no change; state stays TRAIN.
REQ-025 SHALL, on post-increment, set tap1+1 and tap0-1 unless tap1==POST_MAX; at the limit it saturates with no update, no tap_upd and no SETTLE.
REQ-026 SHALL, on post-decrement, set tap1-1 and tap0+1 unless tap1==0; at 0 it saturates the same way.
REQ-027 SHALL keep tap0_code+tap1_code==SUM_CODE in every cycle after reset.
REQ-028 SHALL go to DATA on accepted done (11) the next cycle, with no tap change.
REQ-029 SHALL count cycles spent in TRAIN+SETTLE; when the count reaches TRAIN_LEN, it SHALL go to DATA and set timeout=1.
- Done accepted in the same cycle as the timeout: done wins, timeout stays 0.
REQ-030 SHALL ignore fb_valid in IDLE, SETTLE and DATA; no buffering.
REQ-031 SHALL hold tap codes constant in DATA until the next re-train.

Reset
REQ-032 SHALL, while rst=1 (on posedge clk), set:
- state=IDLE, tx_bit=0, fb_ready=0, tap_upd=0, timeout=0;
- tap1_code=POST_INIT, tap0_code=SUM_CODE-POST_INIT;
- PRBS=7'h7F, counters=0, en history=0.
REQ-033 SHALL let rst override all other inputs; rst asserted mid-TRAIN or mid-SETTLE aborts to the reset values, and en must rise again afterwards to start.

Verification
REQ-034 SHALL be checked: reset, then en rises -> state=1, taps 40/8, and tx_bit from the cycle after TRAIN entry = 1,1,1,1,1,1,1,0.
REQ-035 SHALL be checked: in TRAIN, one accepted 01 -> taps 39/9, tap_upd high 1 cycle, fb_ready low exactly 16 cycles, then state=1.
REQ-036 SHALL be checked: 20 accepted 01 commands (each after its holdoff) -> tap1 stops at 24, tap0 at 24, last 4 commands give no tap_upd; 10 with tap1=0 -> no change.
REQ-037 SHALL be checked: fb_valid with cmd 01 held during SETTLE -> ignored; accepted only on the first TRAIN cycle after holdoff.
REQ-038 SHALL be checked: no done for 1023 cycles -> state=3, timeout=1, tx_bit follows data_in with 1-cycle latency; done and timeout in the same cycle -> timeout=0.
REQ-039 SHALL be checked: en dropped mid-SETTLE -> IDLE next cycle, tx_bit=0, taps held; en rises again -> taps reload to 40/8.

Source files
------------

// File: rtl/tx_fir_tap_ctrl.sv
// Transmit 2-tap FIR coefficient controller.
// Trains the post-cursor tap from back-channel inc/dec/done commands while
// sending PRBS7, keeps the tap pair at a fixed total swing, and then
// passes mission data through once training finishes or times out.
//
// Back-channel handshake: fb_ready is high only in TRAIN (with en high); a
// command is taken on any posedge where fb_valid && fb_ready. Outside TRAIN,
// fb_valid is ignored and nothing is buffered.
module tx_fir_tap_ctrl #(
    parameter int NTAP      = 6,
    parameter int SUM_CODE  = 48,
    parameter int POST_INIT = 8,
    parameter int POST_MAX  = 24,
    parameter int HOLDOFF   = 16,
    parameter int TRAIN_LEN = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            data_in,
    input  logic            fb_valid,
    input  logic [1:0]      fb_cmd,
    output logic            fb_ready,
    output logic            tx_bit,
    output logic [NTAP-1:0] tap0_code,
    output logic [NTAP-1:0] tap1_code,
    output logic            tap_upd,
    output logic [1:0]      state,
    output logic            timeout
);

    localparam int CW = $clog2(TRAIN_LEN + 1);
    localparam int HW = $clog2(HOLDOFF + 1);

    localparam logic [NTAP-1:0] SUM_C      = NTAP'(SUM_CODE);
    localparam logic [NTAP-1:0] POST_INIT_C = NTAP'(POST_INIT);
    localparam logic [NTAP-1:0] POST_MAX_C = NTAP'(POST_MAX);
    localparam logic [CW-1:0]   TCNT_LAST  = CW'(TRAIN_LEN - 1);
    localparam logic [HW-1:0]   HCNT_LAST  = HW'(HOLDOFF - 1);
    localparam logic [6:0]      PRBS_SEED  = 7'h7F;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_DONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRAIN  = 2'd1,
        S_SETTLE = 2'd2,
        S_DATA   = 2'd3
    } state_t;

    state_t          cur_state;
    state_t          nxt_state;
    logic            en_d;
    logic [6:0]      prbs;
    logic [CW-1:0]   tcnt;
    logic [HW-1:0]   hcnt;
    logic [NTAP-1:0] tap1_q;
    logic            timeout_q;
    logic            tx_q;
    logic            upd_q;

    logic en_rise;
    logic in_train;
    logic accept;
    logic tmo_hit;
    logic inc_ok;
    logic dec_ok;
    logic done_acc;
    logic load;
    logic step_inc;
    logic step_dec;
    logic set_tmo;

    // Only the post tap is stored; the main tap is derived so the pair
    // always sums to the fixed swing.
    assign tap1_code = tap1_q;
    assign tap0_code = SUM_C - tap1_q;
    assign tap_upd   = upd_q;
    assign tx_bit    = tx_q;
    assign timeout   = timeout_q;
    assign state     = cur_state;

    assign en_rise  = en & ~en_d;
    assign in_train = (cur_state == S_TRAIN) || (cur_state == S_SETTLE);
    assign fb_ready = (cur_state == S_TRAIN) && en;
    assign accept   = fb_valid && fb_ready;
    assign tmo_hit  = in_train && (tcnt == TCNT_LAST);
    assign done_acc = accept && (fb_cmd == CMD_DONE);
    assign inc_ok   = accept && (fb_cmd == CMD_INC) && (tap1_q != POST_MAX_C);
    assign dec_ok   = accept && (fb_cmd == CMD_DEC) && (tap1_q != '0);

    // Next-state and per-cycle action decode; en low wins over everything.
    always_comb begin
        nxt_state = cur_state;
        load      = 1'b0;
        step_inc  = 1'b0;
        step_dec  = 1'b0;
        set_tmo   = 1'b0;
        if (!en) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE: begin
                    if (en_rise) begin
                        nxt_state = S_TRAIN;
                        load      = 1'b1;
                    end
                end
                S_TRAIN: begin
                    // Done beats a coincident timeout; a timeout beats tap steps.
                    if (done_acc) begin
                        nxt_state = S_DATA;
                    end else if (tmo_hit) begin
                        nxt_state = S_DATA;
                        set_tmo   = 1'b1;
                    end else if (inc_ok) begin
                        nxt_state = S_SETTLE;
                        step_inc  = 1'b1;
                    end else if (dec_ok) begin
                        nxt_state = S_SETTLE;
                        step_dec  = 1'b1;
                    end
                    // CMD_HOLD and saturated steps leave everything unchanged.
                end
                S_SETTLE: begin
                    if (tmo_hit) begin
                        nxt_state = S_DATA;
                        set_tmo   = 1'b1;
                    end else if (hcnt == HCNT_LAST) begin
                        nxt_state = S_TRAIN;
                    end
                end
                S_DATA: begin
                    nxt_state = S_DATA;
                end
                default: begin
                    nxt_state = S_IDLE;
                end
            endcase
        end
    end

    // State register and enable history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
            en_d      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            en_d      <= en;
        end
    end

    // Post tap code and its one-cycle update pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap1_q <= POST_INIT_C;
            upd_q  <= 1'b0;
        end else begin
            upd_q <= step_inc | step_dec;
            if (load) begin
                tap1_q <= POST_INIT_C;
            end else if (step_inc) begin
                tap1_q <= tap1_q + 1'b1;
            end else if (step_dec) begin
                tap1_q <= tap1_q - 1'b1;
            end
        end
    end

    // PRBS7 generator, training cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prbs      <= PRBS_SEED;
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else if (load) begin
            prbs      <= PRBS_SEED;
            tcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_train) begin
                prbs <= {prbs[5:0], prbs[6] ^ prbs[5]};
                tcnt <= tcnt + 1'b1;
            end
            if (set_tmo) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Holdoff counter: restarts on SETTLE entry, runs while in SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
        end else if (cur_state != S_SETTLE) begin
            hcnt <= '0;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Registered line bit: zero when idle or disabling, PRBS while training,
    // data_in (one cycle late) in mission mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= 1'b0;
        end else if (!en || cur_state == S_IDLE) begin
            tx_q <= 1'b0;
        end else if (in_train) begin
            tx_q <= prbs[6];
        end else begin
            tx_q <= data_in;
        end
    end

    logic unused_hold;
    assign unused_hold = (fb_cmd == CMD_HOLD);

endmodule

// File: tb/tb_tx_fir_tap_ctrl.sv
// Directed testbench for tx_fir_tap_ctrl with hand-computed expectations.
module tb_tx_fir_tap_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       data_in;
    logic       fb_valid;
    logic [1:0] fb_cmd;
    logic       fb_ready;
    logic       tx_bit;
    logic [5:0] tap0_code;
    logic [5:0] tap1_code;
    logic       tap_upd;
    logic [1:0] state;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    tx_fir_tap_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .fb_valid  (fb_valid),
        .fb_cmd    (fb_cmd),
        .fb_ready  (fb_ready),
        .tx_bit    (tx_bit),
        .tap0_code (tap0_code),
        .tap1_code (tap1_code),
        .tap_upd   (tap_upd),
        .state     (state),
        .timeout   (timeout)
    );

    // Clock and global watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog sim time exceeded checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Fixed swing must hold in every cycle outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (int'(tap0_code) + int'(tap1_code) !== 48) begin
                failures++;
                $display("FAIL tap_sum got=%0d exp=48", int'(tap0_code) + int'(tap1_code));
            end
        end
    end

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Wait (bounded) for fb_ready, present one command for one cycle.
    task automatic issue_cmd(input logic [1:0] c, output logic upd);
        int n = 0;
        while (fb_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (fb_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_wait got=%b exp=1", fb_ready);
        end
        fb_valid = 1'b1;
        fb_cmd   = c;
        step();
        upd      = tap_upd;
        fb_valid = 1'b0;
        fb_cmd   = 2'b00;
    endtask

    // Drop en for a cycle and raise it; leaves the bench on the first TRAIN cycle.
    task automatic start_train();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL start_train_state got=%0d exp=1", state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; data_in = 1'b0; fb_valid = 1'b0; fb_cmd = 2'b00;
        repeat (3) step();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (tx_bit !== 1'b0) begin failures++; $display("FAIL rst_tx got=%b exp=0", tx_bit); end
        checks++; if (fb_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", fb_ready); end
        checks++; if (tap_upd !== 1'b0) begin failures++; $display("FAIL rst_upd got=%b exp=0", tap_upd); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
        checks++; if (tap0_code !== 6'd40) begin failures++; $display("FAIL rst_tap0 got=%0d exp=40", tap0_code); end
        checks++; if (tap1_code !== 6'd8) begin failures++; $display("FAIL rst_tap1 got=%0d exp=8", tap1_code); end
        rst = 1'b0;
        step();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL post_rst_idle got=%0d exp=0", state); end
    endtask

    task automatic test_train_entry();
        logic [7:0] exp_seq;
        exp_seq = 8'b1111_1110;
        en = 1'b1;
        step();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL entry_state got=%0d exp=1", state); end
        checks++; if (tap0_code !== 6'd40 || tap1_code !== 6'd8) begin
            failures++; $display("FAIL entry_taps got=%0d/%0d exp=40/8", tap0_code, tap1_code); end
        checks++; if (fb_ready !== 1'b1) begin failures++; $display("FAIL entry_ready got=%b exp=1", fb_ready); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (tx_bit !== exp_seq[7-i]) begin
                failures++;
                $display("FAIL prbs_bit%0d got=%b exp=%b", i, tx_bit, exp_seq[7-i]);
            end
        end
    endtask

    task automatic test_post_inc();
        logic u;
        int   low;
        issue_cmd(2'b01, u);
        checks++; if (u !== 1'b1) begin failures++; $display("FAIL inc_upd got=%b exp=1", u); end
        checks++; if (tap0_code !== 6'd39 || tap1_code !== 6'd9) begin
            failures++; $display("FAIL inc_taps got=%0d/%0d exp=39/9", tap0_code, tap1_code); end
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL inc_settle got=%0d exp=2", state); end
        low = (fb_ready === 1'b0) ? 1 : 0;
        step();
        checks++; if (tap_upd !== 1'b0) begin failures++; $display("FAIL inc_upd_pulse got=%b exp=0", tap_upd); end
        while (fb_ready === 1'b0 && low < 100) begin
            low++;
            step();
        end
        checks++; if (low !== 16) begin failures++; $display("FAIL holdoff_len got=%0d exp=16", low); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL holdoff_return got=%0d exp=1", state); end
    endtask

    task automatic test_settle_ignore();
        // tap1 is 9 on entry
        fb_valid = 1'b1; fb_cmd = 2'b01;
        step();
        checks++; if (tap1_code !== 6'd10 || tap_upd !== 1'b1) begin
            failures++; $display("FAIL ign_first got=%0d/%b exp=10/1", tap1_code, tap_upd); end
        repeat (15) step();
        checks++; if (state !== 2'd2 || tap1_code !== 6'd10) begin
            failures++; $display("FAIL ign_settle got=%0d/%0d exp=2/10", state, tap1_code); end
        step();
        checks++; if (state !== 2'd1 || tap1_code !== 6'd10) begin
            failures++; $display("FAIL ign_train got=%0d/%0d exp=1/10", state, tap1_code); end
        step();
        checks++; if (state !== 2'd2 || tap1_code !== 6'd11 || tap_upd !== 1'b1) begin
            failures++; $display("FAIL ign_accept got=%0d/%0d/%b exp=2/11/1", state, tap1_code, tap_upd); end
        fb_valid = 1'b0; fb_cmd = 2'b00;
    endtask

    task automatic test_done();
        logic u;
        issue_cmd(2'b11, u);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL done_state got=%0d exp=3", state); end
        checks++; if (u !== 1'b0 || tap1_code !== 6'd11) begin
            failures++; $display("FAIL done_taps got=%b/%0d exp=0/11", u, tap1_code); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL done_timeout got=%b exp=0", timeout); end
        fb_valid = 1'b1; fb_cmd = 2'b01;
        repeat (5) step();
        checks++; if (state !== 2'd3 || tap1_code !== 6'd11 || fb_ready !== 1'b0) begin
            failures++; $display("FAIL data_hold got=%0d/%0d/%b exp=3/11/0", state, tap1_code, fb_ready); end
        fb_valid = 1'b0; fb_cmd = 2'b00;
    endtask

    task automatic test_saturation();
        logic u;
        int   exp_t;
        start_train();
        for (int i = 0; i < 20; i++) begin
            issue_cmd(2'b01, u);
            exp_t = (9 + i > 24) ? 24 : 9 + i;
            checks++;
            if (tap1_code !== 6'(exp_t) || u !== (i < 16)) begin
                failures++;
                $display("FAIL sat_inc%0d got=%0d/%b exp=%0d/%b", i, tap1_code, u, exp_t, (i < 16));
            end
        end
        checks++; if (tap0_code !== 6'd24 || state !== 2'd1) begin
            failures++; $display("FAIL sat_top got=%0d/%0d exp=24/1", tap0_code, state); end
        for (int i = 0; i < 34; i++) begin
            issue_cmd(2'b10, u);
            exp_t = (23 - i < 0) ? 0 : 23 - i;
            checks++;
            if (tap1_code !== 6'(exp_t) || u !== (i < 24)) begin
                failures++;
                $display("FAIL sat_dec%0d got=%0d/%b exp=%0d/%b", i, tap1_code, u, exp_t, (i < 24));
            end
        end
        checks++; if (tap0_code !== 6'd48 || state !== 2'd1) begin
            failures++; $display("FAIL sat_bottom got=%0d/%0d exp=48/1", tap0_code, state); end
        issue_cmd(2'b00, u);
        checks++; if (u !== 1'b0 || state !== 2'd1 || tap1_code !== 6'd0) begin
            failures++; $display("FAIL hold_cmd got=%b/%0d/%0d exp=0/1/0", u, state, tap1_code); end
    endtask

    task automatic test_en_drop_settle();
        logic u;
        start_train();
        issue_cmd(2'b01, u);
        repeat (3) step();
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL drop_pre got=%0d exp=2", state); end
        en = 1'b0;
        step();
        checks++; if (state !== 2'd0 || tx_bit !== 1'b0) begin
            failures++; $display("FAIL drop_idle got=%0d/%b exp=0/0", state, tx_bit); end
        checks++; if (tap0_code !== 6'd39 || tap1_code !== 6'd9) begin
            failures++; $display("FAIL drop_taps got=%0d/%0d exp=39/9", tap0_code, tap1_code); end
        en = 1'b1;
        step();
        checks++; if (state !== 2'd1 || tap0_code !== 6'd40 || tap1_code !== 6'd8) begin
            failures++; $display("FAIL drop_reload got=%0d/%0d/%0d exp=1/40/8", state, tap0_code, tap1_code); end
    endtask

    task automatic test_rst_mid_settle();
        logic u;
        issue_cmd(2'b01, u);
        rst = 1'b1;
        step();
        checks++; if (state !== 2'd0 || tap1_code !== 6'd8 || tap_upd !== 1'b0 || fb_ready !== 1'b0) begin
            failures++; $display("FAIL rst_abort got=%0d/%0d/%b/%b exp=0/8/0/0", state, tap1_code, tap_upd, fb_ready); end
        en = 1'b0; rst = 1'b0;
        step();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_stay_idle got=%0d exp=0", state); end
        en = 1'b1;
        step();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL rst_restart got=%0d exp=1", state); end
    endtask

    task automatic test_timeout();
        logic [5:0] pat;
        pat = 6'b101100;
        start_train();
        repeat (1022) step();
        checks++; if (state !== 2'd1 || timeout !== 1'b0) begin
            failures++; $display("FAIL tmo_before got=%0d/%b exp=1/0", state, timeout); end
        step();
        checks++; if (state !== 2'd3 || timeout !== 1'b1) begin
            failures++; $display("FAIL tmo_hit got=%0d/%b exp=3/1", state, timeout); end
        for (int i = 0; i < 6; i++) begin
            data_in = pat[i];
            step();
            checks++;
            if (tx_bit !== pat[i]) begin
                failures++; $display("FAIL data_lat%0d got=%b exp=%b", i, tx_bit, pat[i]);
            end
        end
        data_in = 1'b0;
    endtask

    task automatic test_done_timeout_tie();
        start_train();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL tie_clear got=%b exp=0", timeout); end
        repeat (1022) step();
        fb_valid = 1'b1; fb_cmd = 2'b11;
        step();
        fb_valid = 1'b0; fb_cmd = 2'b00;
        checks++; if (state !== 2'd3 || timeout !== 1'b0) begin
            failures++; $display("FAIL tie got=%0d/%b exp=3/0", state, timeout); end
    endtask

    initial begin
        test_reset();
        test_train_entry();
        test_post_inc();
        test_settle_ignore();
        test_done();
        test_saturation();
        test_en_drop_settle();
        test_rst_mid_settle();
        test_timeout();
        test_done_timeout_tie();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
